// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus controller: memory map, slave indices,
// FSM state encoding and the latched request record.
package cpu_bus_pkg;

    localparam int ADDR_W     = 27;
    localparam int DATA_W     = 32;
    localparam int NUM_SLAVES = 3;

    // Word-address regions; SDRAM starts at address zero so only its limit is needed
    localparam logic [ADDR_W-1:0] SDRAM_LIMIT = 27'h07F_FFFF;
    localparam logic [ADDR_W-1:0] FLASH_BASE  = 27'h080_0000;
    localparam logic [ADDR_W-1:0] FLASH_LIMIT = 27'h0BF_FFFF;
    localparam logic [ADDR_W-1:0] IO_BASE     = 27'h0C0_0000;
    localparam logic [ADDR_W-1:0] IO_LIMIT    = 27'h0C7_FFFF;

    localparam logic [1:0] SLV_SDRAM = 2'd0;
    localparam logic [1:0] SLV_FLASH = 2'd1;
    localparam logic [1:0] SLV_IO    = 2'd2;

    localparam logic [DATA_W-1:0] DEFAULT_ERR_DATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ERR  = 2'd2,
        ST_DONE = 2'd3
    } busState_t;

    // Copy of the accepted CPU transfer, held stable while a slave works on it
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              we;
        logic [1:0]        slave;
    } busReq_t;

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational address decoder: maps a word address and direction onto a
// slave index, flagging holes in the map and writes to read-only flash.
module bus_addr_decoder
    import cpu_bus_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_we,
    output logic [1:0]        o_slave,
    output logic              o_unmapped,
    output logic              o_illegal
);

    logic w_isSdram;
    logic w_isFlash;
    logic w_isIo;

    assign w_isSdram = (i_addr <= SDRAM_LIMIT);
    assign w_isFlash = (i_addr >= FLASH_BASE) && (i_addr <= FLASH_LIMIT);
    assign w_isIo    = (i_addr >= IO_BASE) && (i_addr <= IO_LIMIT);

    // Pick the slave index; unmapped addresses default to SDRAM but are flagged
    always_comb begin
        o_slave    = SLV_SDRAM;
        o_unmapped = 1'b0;
        o_illegal  = 1'b0;
        if (w_isFlash) begin
            o_slave   = SLV_FLASH;
            o_illegal = i_we;
        end else if (w_isIo) begin
            o_slave = SLV_IO;
        end else if (!w_isSdram) begin
            o_unmapped = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_bus_controller.sv
// CPU bus target: decodes each transfer, runs a req/ack handshake with one of
// three slaves under a timeout, and returns data with a one-cycle done pulse.
module cpu_bus_controller
    import cpu_bus_pkg::*;
#(
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              bus_we,
    input  logic              bus_start,
    output logic [DATA_W-1:0] bus_q,
    output logic              bus_done,
    output logic              busy,
    output logic [ADDR_W-1:0] s0_addr,
    output logic [DATA_W-1:0] s0_data,
    output logic              s0_we,
    output logic              s0_req,
    input  logic [DATA_W-1:0] s0_q,
    input  logic              s0_ack,
    output logic [ADDR_W-1:0] s1_addr,
    output logic [DATA_W-1:0] s1_data,
    output logic              s1_we,
    output logic              s1_req,
    input  logic [DATA_W-1:0] s1_q,
    input  logic              s1_ack,
    output logic [ADDR_W-1:0] s2_addr,
    output logic [DATA_W-1:0] s2_data,
    output logic              s2_we,
    output logic              s2_req,
    input  logic [DATA_W-1:0] s2_q,
    input  logic              s2_ack,
    output logic              err_unmapped,
    output logic              err_timeout,
    input  logic              err_clr
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    busState_t             r_state;
    busState_t             w_nextState;
    busReq_t               r_req;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_W-1:0]     r_q;
    logic                  r_errUnmapped;
    logic                  r_errTimeout;

    logic [1:0]            w_decSlave;
    logic                  w_decUnmapped;
    logic                  w_decIllegal;
    logic                  w_accept;
    logic [NUM_SLAVES-1:0] w_reqVec;
    logic [NUM_SLAVES-1:0] w_ackVec;
    logic                  w_ack;
    logic                  w_timeout;
    logic [DATA_W-1:0]     w_slvQ;

    bus_addr_decoder u_decoder (
        .i_addr     (bus_addr),
        .i_we       (bus_we),
        .o_slave    (w_decSlave),
        .o_unmapped (w_decUnmapped),
        .o_illegal  (w_decIllegal)
    );

    // A new transfer is only taken when the controller is free or just finishing
    assign w_accept = bus_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Only the latched slave sees req, and only its ack counts while req is up
    assign w_reqVec  = (r_state == ST_REQ) ? (NUM_SLAVES'(1) << r_req.slave) : '0;
    assign w_ackVec  = {s2_ack, s1_ack, s0_ack} & w_reqVec;
    assign w_ack     = |w_ackVec;
    assign w_timeout = (r_state == ST_REQ) && !w_ack && (r_count == CNT_LAST);

    // Return-data mux from the latched slave
    always_comb begin
        w_slvQ = s0_q;
        case (r_req.slave)
            SLV_FLASH: w_slvQ = s1_q;
            SLV_IO:    w_slvQ = s2_q;
            default:   w_slvQ = s0_q;
        endcase
    end

    // State register; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: IDLE/DONE accept, REQ waits for ack or timeout, ERR finishes immediately
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus_start) begin
                    w_nextState = (w_decUnmapped || w_decIllegal) ? ST_ERR : ST_REQ;
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (w_ack || w_timeout) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_ERR:  w_nextState = ST_DONE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Latch the accepted transfer so slave ports stay stable while the CPU moves on
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req <= '0;
        end else if (w_accept) begin
            r_req.addr  <= bus_addr;
            r_req.data  <= bus_data;
            r_req.we    <= bus_we;
            r_req.slave <= w_decSlave;
        end
    end

    // Saturating wait counter, restarted with every accepted transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= '0;
        end else if ((r_state == ST_REQ) && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Capture the response: slave data on read ack, zero on write ack, error data otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if ((r_state == ST_REQ) && w_ack) begin
            r_q <= r_req.we ? '0 : w_slvQ;
        end else if (w_timeout || (r_state == ST_ERR)) begin
            r_q <= ERR_DATA;
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_errUnmapped <= 1'b0;
            r_errTimeout  <= 1'b0;
        end else begin
            if (r_state == ST_ERR) begin
                r_errUnmapped <= 1'b1;
            end else if (err_clr) begin
                r_errUnmapped <= 1'b0;
            end
            if (w_timeout) begin
                r_errTimeout <= 1'b1;
            end else if (err_clr) begin
                r_errTimeout <= 1'b0;
            end
        end
    end

    assign bus_q        = r_q;
    assign bus_done     = (r_state == ST_DONE);
    assign busy         = (r_state != ST_IDLE);
    assign err_unmapped = r_errUnmapped;
    assign err_timeout  = r_errTimeout;

    assign s0_addr = r_req.addr;
    assign s0_data = r_req.data;
    assign s0_we   = r_req.we;
    assign s0_req  = w_reqVec[0];
    assign s1_addr = r_req.addr;
    assign s1_data = r_req.data;
    assign s1_we   = r_req.we;
    assign s1_req  = w_reqVec[1];
    assign s2_addr = r_req.addr;
    assign s2_data = r_req.data;
    assign s2_we   = r_req.we;
    assign s2_req  = w_reqVec[2];

endmodule
